// File: rtl/decoder_nto2n_scan.sv
`default_nettype none
// ============================================================================
// Module   : decoder_nto2n_scan
// Purpose  : N-to-2^N registered one-hot/one-cold decoder with self-timed scan
//            mode that walks the active line with a programmable dwell.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_nto2n_scan #(
    parameter int N          = 2,
    parameter int DWELL_W    = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [N-1:0]         sel,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic                 load,
    output logic [(2**N)-1:0]    Q,
    output logic [N-1:0]         idx,
    output logic                 wrap,
    output logic                 busy
);

    localparam int              c_W        = 2**N;
    localparam logic [c_W-1:0]  c_INACTIVE = (ACTIVE_LOW != 0) ? {c_W{1'b1}} : {c_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_W-1:0]       r_q;
    logic [N-1:0]         r_idx;
    logic [DWELL_W-1:0]   r_cnt;
    logic                 r_wrap;
    logic                 r_busy;
    logic [N-1:0]         w_idx_inc;

    function automatic logic [c_W-1:0] f_decode(input logic [N-1:0] s);
        logic [c_W-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~v : v;
    endfunction

    assign w_idx_inc = r_idx + N'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= c_INACTIVE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (!en) begin
                // idx deliberately keeps its last value while idle
                r_state <= S_IDLE;
                r_q     <= c_INACTIVE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else if (!mode) begin
                r_state <= S_DIRECT;
                r_idx   <= sel;
                r_q     <= f_decode(sel);
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                r_state <= S_SCAN;
                r_busy  <= 1'b1;
                if ((r_state != S_SCAN) || load) begin
                    r_idx <= sel;
                    r_q   <= f_decode(sel);
                    r_cnt <= '0;
                end else if (r_cnt == dwell) begin
                    r_idx  <= w_idx_inc;
                    r_q    <= f_decode(w_idx_inc);
                    r_cnt  <= '0;
                    r_wrap <= (w_idx_inc == '0);
                end else begin
                    r_cnt <= r_cnt + DWELL_W'(1);
                end
            end
        end
    end

    assign Q    = r_q;
    assign idx  = r_idx;
    assign wrap = r_wrap;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_decoder_nto2n_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_nto2n_scan
// Purpose  : Directed bench for decoder_nto2n_scan (N=2 active-high and
//            N=3 active-low instances) with a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_nto2n_scan;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // N=2, active-high instance
    logic       rst, en, mode, load;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic [3:0] q;
    logic [1:0] idx;
    logic       wrap, busy;

    // N=3, active-low instance
    logic       rst2, en2, mode2, load2;
    logic [2:0] sel2;
    logic [7:0] dwell2;
    logic [7:0] q2;
    logic [2:0] idx2;
    logic       wrap2, busy2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] q;
        logic [1:0] idx;
        logic       wrap;
        logic       busy;
    } exp_t;

    typedef struct packed {
        logic [7:0] q;
        logic [2:0] idx;
        logic       wrap;
        logic       busy;
    } exp8_t;

    exp_t  sb[$];
    exp8_t sb8[$];

    decoder_nto2n_scan #(.N(2), .DWELL_W(8), .ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
        .load(load), .Q(q), .idx(idx), .wrap(wrap), .busy(busy)
    );

    decoder_nto2n_scan #(.N(3), .DWELL_W(8), .ACTIVE_LOW(1)) u_dut8 (
        .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .sel(sel2), .dwell(dwell2),
        .load(load2), .Q(q2), .idx(idx2), .wrap(wrap2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Push expectation, clock once, then pop and compare 1 time unit after the edge
    task automatic cyc(input string tag, input logic [3:0] eq, input logic [1:0] ei,
                       input logic ew, input logic eb);
        exp_t e;
        sb.push_back('{q: eq, idx: ei, wrap: ew, busy: eb});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".Q"},    {4'b0, q},      {4'b0, e.q});
        chk({tag, ".idx"},  {6'b0, idx},    {6'b0, e.idx});
        chk({tag, ".wrap"}, {7'b0, wrap},   {7'b0, e.wrap});
        chk({tag, ".busy"}, {7'b0, busy},   {7'b0, e.busy});
    endtask

    task automatic cyc8(input string tag, input logic [7:0] eq, input logic [2:0] ei,
                        input logic ew, input logic eb);
        exp8_t e;
        sb8.push_back('{q: eq, idx: ei, wrap: ew, busy: eb});
        @(posedge clk);
        #1;
        e = sb8.pop_front();
        chk({tag, ".Q"},    q2,              e.q);
        chk({tag, ".idx"},  {5'b0, idx2},    {5'b0, e.idx});
        chk({tag, ".wrap"}, {7'b0, wrap2},   {7'b0, e.wrap});
        chk({tag, ".busy"}, {7'b0, busy2},   {7'b0, e.busy});
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0; load = 1'b0; sel = 2'd3; dwell = 8'd0;
        rst2 = 1'b1; en2 = 1'b0; mode2 = 1'b0; load2 = 1'b0; sel2 = 3'd0; dwell2 = 8'd0;

        // Reset dominates even with en=1, sel=3
        cyc("reset0", 4'b0000, 2'd0, 1'b0, 1'b0);
        cyc("reset1", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Direct decode of every select value
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            for (int k = 0; k < 10; k++)
                cyc($sformatf("direct_s%0d", s), 4'(1 << s), 2'(s), 1'b0, 1'b0);
        end

        // Scan from 1 with dwell=2: each line for 3 cycles, wrap on first 0001
        sel = 2'd1; dwell = 8'd2; mode = 1'b1;
        for (int k = 0; k < 13; k++)
            cyc($sformatf("scan_d2_%0d", k), 4'(1 << ((1 + k / 3) % 4)),
                2'((1 + k / 3) % 4), (k == 9), 1'b1);

        // Drop to direct sel=0, then scan with dwell=0
        mode = 1'b0; sel = 2'd0;
        cyc("direct0", 4'b0001, 2'd0, 1'b0, 1'b0);
        mode = 1'b1; dwell = 8'd0;
        for (int k = 0; k < 6; k++)
            cyc($sformatf("scan_d0_%0d", k), 4'(1 << (k % 4)), 2'(k % 4), (k == 4), 1'b1);

        // Load mid-rotation: restart at 2 without a wrap pulse
        sel = 2'd2; load = 1'b1;
        cyc("load2", 4'b0100, 2'd2, 1'b0, 1'b1);
        load = 1'b0;
        cyc("after_load_a", 4'b1000, 2'd3, 1'b0, 1'b1);
        cyc("after_load_b", 4'b0001, 2'd0, 1'b1, 1'b1);

        // en=0 mid-scan: outputs inactive, idx holds
        en = 1'b0;
        cyc("en_off", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Re-enable at 3 with dwell=2: full dwell before advancing
        en = 1'b1; sel = 2'd3; dwell = 8'd2;
        cyc("reen_0", 4'b1000, 2'd3, 1'b0, 1'b1);
        cyc("reen_1", 4'b1000, 2'd3, 1'b0, 1'b1);
        cyc("reen_2", 4'b1000, 2'd3, 1'b0, 1'b1);
        cyc("reen_3", 4'b0001, 2'd0, 1'b1, 1'b1);

        // Reset mid-scan beats load
        rst = 1'b1; load = 1'b1; sel = 2'd2;
        cyc("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; load = 1'b0;
        cyc("post_rst", 4'b0100, 2'd2, 1'b0, 1'b1);

        // N=3 active-low instance
        en = 1'b0;
        cyc8("al_reset", 8'b1111_1111, 3'd0, 1'b0, 1'b0);
        rst2 = 1'b0; en2 = 1'b1; mode2 = 1'b0; sel2 = 3'd5;
        cyc8("al_direct5", 8'b1101_1111, 3'd5, 1'b0, 1'b0);
        sel2 = 3'd7; dwell2 = 8'd1; mode2 = 1'b1;
        cyc8("al_scan7_0", 8'b0111_1111, 3'd7, 1'b0, 1'b1);
        cyc8("al_scan7_1", 8'b0111_1111, 3'd7, 1'b0, 1'b1);
        cyc8("al_scan0",   8'b1111_1110, 3'd0, 1'b1, 1'b1);
        cyc8("al_scan0_b", 8'b1111_1110, 3'd0, 1'b0, 1'b1);
        cyc8("al_scan1",   8'b1111_1101, 3'd1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_nto2n_scan.md
Name: decoder_nto2n_scan

Overview:
Parametrised N-to-2^N one-hot decoder with registered outputs. It generalises the 2-to-4 decoder in two ways: select width is a parameter, and it adds a self-timed scan mode that walks the active output through all 2^N lines with a programmable dwell time. It drives column/row strobes, such as LED digit multiplexing or keypad scanning, and is also usable as a plain registered decoder.

Parameters:
N, 2, select width; output width is 2^N
DWELL_W, 8, width of dwell-count input and internal dwell counter
ACTIVE_LOW, 0, 0: selected line = 1, others 0; 1: selected line = 0, others 1 (inactive pattern is all ones)

Ports:
clk  input  1  single clock, all state changes on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  1 = outputs driven per mode; 0 = outputs inactive, scan halted
mode  input  1  0 = direct decode; 1 = scan
sel  input  N  direct-mode select; scan start/reload index
dwell  input  DWELL_W  scan dwell: each line stays active dwell+1 cycles
load  input  1  scan mode: restart scan at sel (single-cycle strobe)
Q  output  2^N  registered one-hot (or one-cold) decode; Q[i] corresponds to index i
idx  output  N  registered index currently decoded
wrap  output  1  one-cycle pulse when scan advances from 2^N-1 to 0
busy  output  1  1 while in SCAN state

Behaviour:
- All outputs registered; no combinational path from inputs to outputs.
- Reset (rst=1 at edge, highest priority, including mid-scan): state=IDLE, Q=inactive pattern (all 0, or all 1 if ACTIVE_LOW), idx=0, dwell counter cnt=0, wrap=0, busy=0.
- States: IDLE, DIRECT, SCAN. Next state is evaluated every edge: en=0 -> IDLE; en=1, mode=0 -> DIRECT; en=1, mode=1 -> SCAN.
- IDLE: Q inactive, idx holds last value, cnt=0, wrap=0, busy=0.
- DIRECT: each edge, idx<=sel and Q<=decode(sel). Latency is one cycle from sel to Q. wrap=0, busy=0. load is ignored.
- Entry to SCAN from IDLE or DIRECT: idx<=sel, cnt<=0, Q<=decode(sel), busy<=1, wrap=0.
- In SCAN, priority order per edge is rst > load > advance.
- load=1 in SCAN: idx<=sel, cnt<=0, no wrap pulse.
- Advance condition in SCAN, when cnt==dwell: cnt<=0, idx<=idx+1 modulo 2^N, and Q follows on the same edge.
- wrap<=1 for exactly the cycle in which idx becomes 0 via advance. It is not asserted on entry, on load, or on direct select 0.
- Otherwise in SCAN: cnt<=cnt+1, and idx and Q hold.
- dwell is sampled live each cycle. If dwell is lowered below the current cnt, advance occurs when cnt wraps modulo 2^DWELL_W. Software must change dwell only around load.
- dwell=0: advance every cycle.
- Leaving SCAN (en fall or mode=0): cnt<=0, busy<=0 on that edge, and Q updates per the new state.
- Q is always exactly one active line or all inactive; never multi-hot.
- N=1 is legal (2 outputs); wrap then pulses every other advance.

Test Plan:
- N=2, ACTIVE_LOW=0; hold rst=1 for 2 cycles with en=1, sel=3 -> Q=0000, idx=0, busy=0, wrap=0 throughout reset.
- Direct mode: en=1, mode=0, sel=0,1,2,3 for 10 cycles each -> Q=0001,0010,0100,1000, each appearing one clock after the sel change; busy=0.
- Scan mode: sel=1, dwell=2, mode 0->1 -> Q=0010 for 3 cycles, then 0100 x3, 1000 x3, 0001 x3 (wrap=1 only on the first 0001 cycle), then 0010; busy=1.
- dwell=0 scan from sel=0 -> Q rotates 0001,0010,0100,1000 on every clock; wrap pulses every 4th cycle; load with sel=2 mid-rotation -> next Q=0100 and the count restarts, no wrap pulse.
- Mid-scan en=0 -> Q=0000 next cycle and busy=0; re-enable with sel=3 -> scan restarts at Q=1000 with a full dwell. rst asserted mid-scan -> reset values on the next edge regardless of load.
- N=3, ACTIVE_LOW=1, direct sel=5 -> Q=8'b11011111. Scan from 7 with dwell=1 -> Q=01111111 to 11111110 after 2 cycles, wrap=1.
